// File: rtl/mem_access_unit.sv
// LC-3b MEM-stage data-access controller: issues dmem reads/writes and stalls the pipeline.
// Define MEM_INDIRECT_EN to give LDI/STI a pointer fetch; otherwise they act as LDR/STR.
module mem_access_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [3:0]  opcode,
  input  logic [15:0] address,
  input  logic [15:0] store_data,
  output logic        mem_stall,
  output logic        mem_done,
  output logic [15:0] load_data,
  output logic [15:0] load_address,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [1:0]  dmem_byte_enable,
  output logic [15:0] dmem_address,
  output logic [15:0] dmem_wdata,
  input  logic        dmem_resp,
  input  logic [15:0] dmem_rdata
);

  localparam logic [3:0] OP_LDB = 4'b0010;
  localparam logic [3:0] OP_STB = 4'b0011;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;

`ifdef MEM_INDIRECT_EN
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE, S_IND} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;
`endif

  state_t      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] sdata_q, sdata_d;
  logic        dmem_read_q, dmem_read_d;
  logic        dmem_write_q, dmem_write_d;
  logic [1:0]  dmem_byte_enable_q, dmem_byte_enable_d;
  logic [15:0] dmem_address_q, dmem_address_d;
  logic [15:0] dmem_wdata_q, dmem_wdata_d;
  logic [15:0] load_data_q, load_data_d;
  logic [15:0] load_address_q, load_address_d;
  logic        mem_done_q, mem_done_d;

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LDB) || (op == OP_STB) || (op == OP_LDR) ||
           (op == OP_STR) || (op == OP_LDI) || (op == OP_STI);
  endfunction

  function automatic logic is_load_op(input logic [3:0] op);
    return (op == OP_LDB) || (op == OP_LDR) || (op == OP_LDI);
  endfunction

  // Final-access request as {read, write, byte_enable, wdata}; loads always fetch the full word.
  function automatic logic [19:0] access_req(input logic [3:0] op, input logic lane_hi,
                                             input logic [15:0] sd);
    logic [19:0] r;
    if (is_load_op(op)) begin
      r = {1'b1, 1'b0, 2'b11, 16'h0000};
    end else if (op == OP_STB) begin
      r = {1'b0, 1'b1, (lane_hi ? 2'b10 : 2'b01), sd[7:0], sd[7:0]};
    end else begin
      r = {1'b0, 1'b1, 2'b11, sd};
    end
    return r;
  endfunction

  always_comb begin
    state_d            = state_q;
    op_d               = op_q;
    addr_d             = addr_q;
    sdata_d            = sdata_q;
    dmem_read_d        = dmem_read_q;
    dmem_write_d       = dmem_write_q;
    dmem_byte_enable_d = dmem_byte_enable_q;
    dmem_address_d     = dmem_address_q;
    dmem_wdata_d       = dmem_wdata_q;
    load_data_d        = load_data_q;
    load_address_d     = load_address_q;
    mem_done_d         = 1'b0;

    case (state_q)
      S_IDLE: begin
        {dmem_read_d, dmem_write_d, dmem_byte_enable_d, dmem_wdata_d} = '0;
        dmem_address_d = '0;
        if (req_valid && is_mem_op(opcode)) begin
          op_d    = opcode;
          addr_d  = address;
          sdata_d = store_data;
`ifdef MEM_INDIRECT_EN
          if ((opcode == OP_LDI) || (opcode == OP_STI)) begin
            state_d            = S_IND;
            dmem_read_d        = 1'b1;
            dmem_byte_enable_d = 2'b11;
            dmem_address_d     = address;
          end else
`endif
          begin
            state_d        = S_ACCESS;
            {dmem_read_d, dmem_write_d, dmem_byte_enable_d, dmem_wdata_d} =
              access_req(opcode, address[0], store_data);
            dmem_address_d = address;
          end
        end
      end
`ifdef MEM_INDIRECT_EN
      S_IND: begin
        // Pointer returned by the first read becomes the final access address.
        if (dmem_resp) begin
          state_d        = S_ACCESS;
          addr_d         = dmem_rdata;
          {dmem_read_d, dmem_write_d, dmem_byte_enable_d, dmem_wdata_d} =
            access_req(op_q, dmem_rdata[0], sdata_q);
          dmem_address_d = dmem_rdata;
        end
      end
`endif
      S_ACCESS: begin
        if (dmem_resp) begin
          state_d        = S_DONE;
          mem_done_d     = 1'b1;
          load_address_d = addr_q;
          if (is_load_op(op_q)) load_data_d = dmem_rdata;
          {dmem_read_d, dmem_write_d, dmem_byte_enable_d, dmem_wdata_d} = '0;
          dmem_address_d = '0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        {dmem_read_d, dmem_write_d, dmem_byte_enable_d, dmem_wdata_d} = '0;
        dmem_address_d = '0;
      end
      default: begin
        state_d = S_IDLE;
        {dmem_read_d, dmem_write_d, dmem_byte_enable_d, dmem_wdata_d} = '0;
        dmem_address_d = '0;
      end
    endcase
  end

  // Stall must be visible in the detect cycle, so it is decoded from state rather than registered.
  always_comb begin
    mem_stall = 1'b0;
    case (state_q)
      S_IDLE:   mem_stall = req_valid && is_mem_op(opcode);
      S_ACCESS: mem_stall = 1'b1;
`ifdef MEM_INDIRECT_EN
      S_IND:    mem_stall = 1'b1;
`endif
      default:  mem_stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q            <= S_IDLE;
      dmem_read_q        <= 1'b0;
      dmem_write_q       <= 1'b0;
      dmem_byte_enable_q <= 2'b00;
      dmem_address_q     <= 16'h0000;
      dmem_wdata_q       <= 16'h0000;
      load_data_q        <= 16'h0000;
      load_address_q     <= 16'h0000;
      mem_done_q         <= 1'b0;
    end else begin
      state_q            <= state_d;
      dmem_read_q        <= dmem_read_d;
      dmem_write_q       <= dmem_write_d;
      dmem_byte_enable_q <= dmem_byte_enable_d;
      dmem_address_q     <= dmem_address_d;
      dmem_wdata_q       <= dmem_wdata_d;
      load_data_q        <= load_data_d;
      load_address_q     <= load_address_d;
      mem_done_q         <= mem_done_d;
    end
  end

  // Latched instruction fields are only consumed after a fresh capture in IDLE.
  always_ff @(posedge clk) begin
    op_q    <= op_d;
    addr_q  <= addr_d;
    sdata_q <= sdata_d;
  end

  assign mem_done         = mem_done_q;
  assign load_data        = load_data_q;
  assign load_address     = load_address_q;
  assign dmem_read        = dmem_read_q;
  assign dmem_write       = dmem_write_q;
  assign dmem_byte_enable = dmem_byte_enable_q;
  assign dmem_address     = dmem_address_q;
  assign dmem_wdata       = dmem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a request/completion scoreboard.
module tb_mem_access_unit;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LDB = 4'b0010;
  localparam logic [3:0] OP_STB = 4'b0011;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;

  logic        clk, reset, req_valid;
  logic [3:0]  opcode;
  logic [15:0] address, store_data;
  logic        mem_stall, mem_done;
  logic [15:0] load_data, load_address;
  logic        dmem_read, dmem_write;
  logic [1:0]  dmem_byte_enable;
  logic [15:0] dmem_address, dmem_wdata;
  logic        dmem_resp;
  logic [15:0] dmem_rdata;

  mem_access_unit dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .opcode(opcode),
    .address(address), .store_data(store_data), .mem_stall(mem_stall),
    .mem_done(mem_done), .load_data(load_data), .load_address(load_address),
    .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_byte_enable(dmem_byte_enable), .dmem_address(dmem_address),
    .dmem_wdata(dmem_wdata), .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [1:0]  be;
    logic [15:0] addr;
    logic [15:0] wdata;
  } req_t;

  typedef struct packed {
    logic [15:0] ld;
    logic [15:0] la;
  } cmp_t;

  req_t        req_q[$];
  int          lat_q[$];
  logic [15:0] rsp_q[$];
  cmp_t        cmp_q[$];
  logic [15:0] exp_ld;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one memory instruction, acts as the memory, and scores every request and completion.
  task automatic do_mem(input logic [3:0] op, input logic [15:0] a, input logic [15:0] sd,
                        input int k1, input logic [15:0] r1, input int k2,
                        input logic [15:0] r2, input string tag);
    logic        ind, ld, have, done;
    logic [15:0] fa, rv;
    req_t        e, cur;
    cmp_t        cx;
    int          k, cnt, stall_cnt, exp_stall;
    ind = 1'b0;
`ifdef MEM_INDIRECT_EN
    ind = (op == OP_LDI) || (op == OP_STI);
`endif
    ld = (op == OP_LDR) || (op == OP_LDB) || (op == OP_LDI);
    fa = a;
    if (ind) begin
      e.rd = 1'b1; e.wr = 1'b0; e.be = 2'b11; e.addr = a; e.wdata = 16'h0000;
      req_q.push_back(e); lat_q.push_back(k1); rsp_q.push_back(r1);
      fa = r1;
    end
    e.rd    = ld;
    e.wr    = !ld;
    e.be    = (op == OP_STB) ? (fa[0] ? 2'b10 : 2'b01) : 2'b11;
    e.addr  = fa;
    e.wdata = ld ? 16'h0000 : ((op == OP_STB) ? {sd[7:0], sd[7:0]} : sd);
    req_q.push_back(e); lat_q.push_back(k2); rsp_q.push_back(r2);
    if (ld) exp_ld = r2;
    cx.ld = exp_ld; cx.la = fa;
    cmp_q.push_back(cx);
    exp_stall = 1 + k2 + (ind ? k1 : 0);

    req_valid = 1'b1; opcode = op; address = a; store_data = sd;
    #1;
    chk({tag, "_stall_detect"}, mem_stall, 1);
    chk({tag, "_idle_noreq"}, {dmem_read, dmem_write}, 0);
    stall_cnt = 1; have = 1'b0; done = 1'b0; cnt = 0; k = 0; rv = 16'h0; cur = '0;
    @(posedge clk); #1;
    for (int i = 0; i < 64 && !done; i++) begin
      dmem_resp = 1'b0;
      if (mem_done) begin
        chk({tag, "_done_stall"}, mem_stall, 0);
        chk({tag, "_done_noreq"}, {dmem_read, dmem_write}, 0);
        cx = cmp_q.pop_front();
        chk({tag, "_load_data"}, load_data, cx.ld);
        chk({tag, "_load_address"}, load_address, cx.la);
        done = 1'b1;
      end else begin
        if (mem_stall) stall_cnt++;
        if (!have && req_q.size() > 0) begin
          cur = req_q.pop_front(); k = lat_q.pop_front(); rv = rsp_q.pop_front();
          have = 1'b1; cnt = 0;
        end
        chk({tag, "_req"},
            {dmem_read, dmem_write, dmem_byte_enable, dmem_address,
             (dmem_write ? dmem_wdata : 16'h0000)},
            {cur.rd, cur.wr, cur.be, cur.addr, cur.wdata});
        cnt++;
        if (have && cnt == k) begin
          dmem_resp = 1'b1; dmem_rdata = rv; have = 1'b0;
        end
        @(posedge clk); #1;
      end
    end
    dmem_resp = 1'b0;
    dmem_rdata = 16'hA5A5;
    chk({tag, "_complete"}, done, 1);
    chk({tag, "_stall_cycles"}, stall_cnt, exp_stall);
    req_valid = 1'b0; opcode = OP_ADD;
    @(posedge clk); #1;
    chk({tag, "_back_idle"}, {mem_done, mem_stall, dmem_read, dmem_write}, 0);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; opcode = OP_ADD; address = 16'h0;
    store_data = 16'h0; dmem_resp = 1'b0; dmem_rdata = 16'h0; exp_ld = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stall", mem_stall, 0);
    chk("rst_done", mem_done, 0);
    chk("rst_rd_wr", {dmem_read, dmem_write}, 0);
    chk("rst_be", dmem_byte_enable, 0);
    chk("rst_addr", dmem_address, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_load_data", load_data, 0);
    chk("rst_load_address", load_address, 0);
    reset = 1'b0;

    // Reset during ACCESS of an LDR, with a late response that must be ignored.
    req_valid = 1'b1; opcode = OP_LDR; address = 16'h0100;
    @(posedge clk); #1;
    chk("rst_acc_req", {dmem_read, dmem_address}, {1'b1, 16'h0100});
    reset = 1'b1; req_valid = 1'b0; opcode = OP_ADD;
    @(posedge clk); #1;
    chk("rst_acc_drop", {dmem_read, dmem_write, mem_stall}, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    dmem_resp = 1'b1; dmem_rdata = 16'hDEAD;
    @(posedge clk); #1;
    dmem_resp = 1'b0;
    chk("rst_late_resp_ld", load_data, 16'h0000);
    chk("rst_late_resp_done", {mem_done, dmem_read, mem_stall}, 0);

    // Non-memory opcode: no stall, no request.
    req_valid = 1'b1; opcode = OP_ADD; address = 16'h1111; #1;
    chk("add_stall", mem_stall, 0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("add_noreq", {dmem_read, dmem_write, mem_done, mem_stall}, 0);
    end
    req_valid = 1'b0;

    // Response while idle is ignored.
    dmem_resp = 1'b1; dmem_rdata = 16'h7777;
    @(posedge clk); #1;
    dmem_resp = 1'b0;
    chk("idle_resp_ignored", {mem_done, load_data}, {1'b0, 16'h0000});

    do_mem(OP_LDR, 16'h1000, 16'h0000, 0, 16'h0000, 2, 16'hBEEF, "ldr");
    do_mem(OP_STB, 16'h2001, 16'h00A5, 0, 16'h0000, 1, 16'h0000, "stb_hi");
    do_mem(OP_STB, 16'h2002, 16'h1234, 0, 16'h0000, 1, 16'h0000, "stb_lo");
    do_mem(OP_LDI, 16'h3000, 16'h0000, 2, 16'h4000, 1, 16'h1234, "ldi");
    do_mem(OP_STI, 16'h3000, 16'h5555, 1, 16'h5000, 2, 16'h0000, "sti");
    do_mem(OP_LDB, 16'h0007, 16'h0000, 0, 16'h0000, 3, 16'h7788, "ldb");
    do_mem(OP_STR, 16'h0011, 16'hCAFE, 0, 16'h0000, 1, 16'h0000, "str");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
